systolic_input_feeder: RTL and testbench
========================================

// Module: systolic_input_feeder
// PURPOSE
//  Feeds one edge lane of the systolic array. Accepts a parallel vector of DEPTH elements through a
//  valid/ready handshake and emits it serially, element 0 first, one element per enabled cycle.
//  Holds a second vector in a shadow register so back-to-back vectors stream without a bubble.
//  It is the load-side counterpart of the per-column output shifter (serial in, parallel out).
// PARAMETERS
//  DATA_W    8   element width in bits (default tracks the output-buffer element width in config.v)
//  DEPTH     4   elements per vector (default tracks ARRAYHEIGHT)
//  LANE_IDX  0   lane position in the edge; sets skew depth when INPUT_FEEDER_SKEW_EN is defined
// PORTS
//  clk        in   1             clock, all logic on the rising edge
//  rst        in   1             reset; synchronous, active-low
//  in_valid   in   1             in_data is valid
//  in_ready   out  1             feeder can take a vector this cycle
//  in_data    in   DEPTH*DATA_W  vector; element k sits at [k*DATA_W +: DATA_W]
//  out_en     in   1             array advance enable; low freezes all stream state
//  out_valid  out  1             out_data carries a real element
//  out_data   out  DATA_W        element to the array edge; 0 whenever out_valid=0
//  out_last   out  1             out_data is element DEPTH-1 of its vector
// BEHAVIOUR
//  - Reset (rst=0 at a clock edge): active/shadow regs=0, cnt=0, state=IDLE, shadow_full=0.
//    Outputs after reset: out_valid=0, out_data=0, out_last=0, in_ready=0 while rst=0, then 1.
//  - Handshake: accept = in_valid & in_ready. in_ready = rst & ~shadow_full.
//    in_data may change freely when accept=0.
//  - State IDLE: accept loads active and sets cnt=0, ->STREAM.
//    out_valid rises the cycle after accept (latency 1).
//  - State STREAM: out_valid=1, out_data=active[DATA_W-1:0], out_last=(cnt==DEPTH-1).
//    adv = out_en: active shifts right by DATA_W with zero fill, cnt++.
//    out_en=0: everything holds; accepts into shadow are still allowed.
//  - End of vector (adv & cnt==DEPTH-1):
//    shadow_full -> shadow moves to active, cnt=0, stay STREAM, shadow_full=0.
//    else if accept this cycle -> in_data goes straight to active (bypass), stay STREAM.
//    else -> IDLE.
//  - STREAM with no bypass: accept writes shadow, shadow_full=1. Shadow is never overwritten.
//  - Simultaneous accept with a shadow->active move: illegal by construction, since in_ready=0
//    while shadow_full. cnt width = $clog2(DEPTH); it never wraps past DEPTH-1.
//  - Reset mid-stream drops both vectors. No partial output follows reset.
// CONFIGURATION
//  INPUT_FEEDER_SKEW_EN defined:
//    {out_valid, out_last, out_data} pass through a LANE_IDX-stage delay line.
//    The delay line advances only when out_en=1 and resets to 0.
//    LANE_IDX=0 gives zero stages, identical to undefined.
//  INPUT_FEEDER_SKEW_EN undefined:
//    Outputs come directly from the active reg; LANE_IDX is ignored.
//    The array-edge skew is then provided externally.
// STRUCTURE
//  Shared package/config: state typedef {IDLE, STREAM}, default DATA_W/DEPTH constants,
//  element-slice helper.
//  One sub-module: skew_delay_line (params W, STAGES; clk, rst, en, d, q), generated only
//  under INPUT_FEEDER_SKEW_EN.
// TESTING  (DATA_W=8, DEPTH=4)
//  1. Reset held 3 cycles, release
//     -> in_ready=0 during reset, 1 the next cycle; out_valid=0, out_data=0 throughout.
//  2. Single accept of 32'h44332211, out_en=1
//     -> out_data 11,22,33,44 on the 4 cycles after accept; out_last only with 44; then out_valid=0.
//  3. Vector A=32'h04030201 then B=32'h08070605 accepted during A's stream
//     -> 8 consecutive valid cycles 01..08, no bubble; in_ready=0 from B's accept until B moves.
//  4. out_en toggled 1,0,0,1,1,1 during A -> out_data holds 02 across both low cycles;
//     total 4 valid elements; cnt never skips.
//  5. rst pulsed low after 2 elements of A with B in shadow
//     -> next cycle out_valid=0, in_ready=1; no 03/04/B elements ever appear.
//  6. SKEW_EN, LANE_IDX=3, case 2 stimulus -> identical sequence delayed 3 enabled cycles;
//     undefined build matches case 2 exactly.

Source files
------------

// File: rtl/systolic_input_feeder_pkg.sv
// Shared definitions for the systolic input feeder: state encoding, default sizes,
// and the element-slice helper.
package systolic_input_feeder_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    typedef logic [0:0] feeder_state_t;

    localparam feeder_state_t ST_IDLE   = 1'b0;
    localparam feeder_state_t ST_STREAM = 1'b1;

    // Bit offset of element k inside a packed vector of elem_w-bit elements.
    function automatic int elem_lsb(input int k, input int elem_w);
        return k * elem_w;
    endfunction

endpackage

// File: rtl/systolic_input_feeder_skew_delay_line.sv
// Enable-gated delay line of STAGES registers (STAGES=0 is a wire); clears on active-low
// synchronous reset. Used by systolic_input_feeder to stagger lanes at the array edge.
module skew_delay_line #(
    parameter int W      = 8,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (STAGES == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] pipe_q [STAGES];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else if (en) begin
                    pipe_q[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign q = pipe_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_input_feeder.sv
// Parallel-in / serial-out feeder for one edge lane of the systolic array, with a shadow
// vector for bubble-free streaming. Optional lane skew under macro INPUT_FEEDER_SKEW_EN.
module systolic_input_feeder
    import systolic_input_feeder_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int LANE_IDX = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DEPTH*DATA_W-1:0] in_data,
    input  logic                    out_en,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last
);

    localparam int VEC_W = DEPTH * DATA_W;
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

`ifdef INPUT_FEEDER_SKEW_EN
    localparam bit SKEW_ENABLED = 1'b1;
`else
    localparam bit SKEW_ENABLED = 1'b0;
`endif
    localparam int SKEW_STAGES = SKEW_ENABLED ? LANE_IDX : 0;

    feeder_state_t    state_q, state_d;
    logic [VEC_W-1:0] active_q, active_d;
    logic [VEC_W-1:0] shadow_q, shadow_d;
    logic             shadow_full_q, shadow_full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic vec_done;

    assign in_ready = rst & ~shadow_full_q;
    assign accept   = in_valid & in_ready;
    assign vec_done = out_en & (cnt_q == LAST_CNT);

    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        cnt_d         = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    active_d = in_data;
                    cnt_d    = '0;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (vec_done) begin
                    // accept and shadow_full are mutually exclusive: in_ready is low while full.
                    cnt_d = '0;
                    if (shadow_full_q) begin
                        active_d      = shadow_q;
                        shadow_full_d = 1'b0;
                    end else if (accept) begin
                        active_d = in_data;
                    end else begin
                        active_d = '0;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    if (out_en) begin
                        active_d = active_q >> DATA_W;
                        cnt_d    = cnt_q + 1'b1;
                    end
                    if (accept) begin
                        shadow_d      = in_data;
                        shadow_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            cnt_q         <= cnt_d;
        end
    end

    logic              raw_valid;
    logic              raw_last;
    logic [DATA_W-1:0] raw_data;

    assign raw_valid = (state_q == ST_STREAM);
    assign raw_last  = raw_valid & (cnt_q == LAST_CNT);
    assign raw_data  = raw_valid ? active_q[elem_lsb(0, DATA_W) +: DATA_W] : '0;

    generate
        if (SKEW_STAGES > 0) begin : g_skew
            logic [DATA_W+1:0] skew_d;
            logic [DATA_W+1:0] skew_q;

            assign skew_d = {raw_valid, raw_last, raw_data};

            skew_delay_line #(
                .W      (DATA_W + 2),
                .STAGES (SKEW_STAGES)
            ) u_skew (
                .clk (clk),
                .rst (rst),
                .en  (out_en),
                .d   (skew_d),
                .q   (skew_q)
            );

            assign {out_valid, out_last, out_data} = skew_q;
        end else begin : g_direct
            assign out_valid = raw_valid;
            assign out_last  = raw_last;
            assign out_data  = raw_data;
        end
    endgenerate

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Testbench for systolic_input_feeder: vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_systolic_input_feeder;

    localparam int DW = 8;
    localparam int DP = 4;
`ifdef INPUT_FEEDER_SKEW_EN
    localparam int SKEW = 3;
`else
    localparam int SKEW = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_en;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_last;

    logic          s_ready;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_last;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    systolic_input_feeder #(.DATA_W(DW), .DEPTH(DP), .LANE_IDX(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_en    (out_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    systolic_input_feeder #(.DATA_W(DW), .DEPTH(DP), .LANE_IDX(3)) dut_skew (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (s_ready),
        .in_data   (in_data),
        .out_en    (out_en),
        .out_valid (s_valid),
        .out_data  (s_data),
        .out_last  (s_last)
    );

    typedef struct {
        logic        r;
        logic        iv;
        logic [31:0] d;
        logic        en;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic        er;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic r, input logic iv, input logic [31:0] d, input logic en,
                        input logic ev, input logic [7:0] ed, input logic el, input logic er);
        vec_t v;
        v.r = r; v.iv = iv; v.d = d; v.en = en;
        v.ev = ev; v.ed = ed; v.el = el; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs for one cycle; outputs are then inspected before the next rising edge.
    task automatic drive(input logic r, input logic iv, input logic [31:0] d, input logic en);
        @(negedge clk);
        rst      = r;
        in_valid = iv;
        in_data  = d;
        out_en   = en;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed,
                           input logic el, input logic er);
        chk({tag, " valid"}, out_valid, ev);
        chk({tag, " data"},  out_data,  ed);
        chk({tag, " last"},  out_last,  el);
        chk({tag, " ready"}, in_ready,  er);
    endtask

    // Reference model: remaining elements of the streaming vector plus one shadow vector.
    logic [7:0]  m_cur[$];
    logic [31:0] m_shadow;
    bit          m_shadow_full;
    logic [9:0]  m_dq[$];

    task automatic m_load(input logic [31:0] v);
        m_cur.delete();
        for (int k = 0; k < DP; k++) begin
            m_cur.push_back(v[k*DW +: DW]);
        end
    endtask

    initial begin
        logic        r, iv, en;
        logic [31:0] d;
        logic        m_valid, m_last, m_ready;
        logic [7:0]  m_data;
        logic [9:0]  sk;
        bit          acc;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_en = 1'b1;
        @(posedge clk);

        // Reset, single vector, shadowed pair, and last-cycle bypass.
        addv(0, 0, 32'h0,        1, 0, 8'h00, 0, 0);
        addv(0, 1, 32'hDEADBEEF, 1, 0, 8'h00, 0, 0);
        addv(0, 0, 32'h0,        1, 0, 8'h00, 0, 0);
        addv(1, 0, 32'h0,        1, 0, 8'h00, 0, 1);
        addv(1, 1, 32'h44332211, 1, 0, 8'h00, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h11, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h22, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h33, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h44, 1, 1);
        addv(1, 0, 32'h0,        1, 0, 8'h00, 0, 1);
        addv(1, 1, 32'h04030201, 1, 0, 8'h00, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h01, 0, 1);
        addv(1, 1, 32'h08070605, 1, 1, 8'h02, 0, 1);
        addv(1, 1, 32'h99999999, 1, 1, 8'h03, 0, 0);
        addv(1, 0, 32'h0,        1, 1, 8'h04, 1, 0);
        addv(1, 0, 32'h0,        1, 1, 8'h05, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h06, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h07, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h08, 1, 1);
        addv(1, 0, 32'h0,        1, 0, 8'h00, 0, 1);
        addv(1, 1, 32'h0D0C0B0A, 1, 0, 8'h00, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h0A, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h0B, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h0C, 0, 1);
        addv(1, 1, 32'h14131211, 1, 1, 8'h0D, 1, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h11, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h12, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h13, 0, 1);
        addv(1, 0, 32'h0,        1, 1, 8'h14, 1, 1);
        addv(1, 0, 32'h0,        1, 0, 8'h00, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].en);
            chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].er);
        end

        // out_en stalls mid-vector: element 02 must hold and no element may be skipped.
        drive(1, 1, 32'h04030201, 1); chk_out("stall acc", 0, 8'h00, 0, 1);
        drive(1, 0, 32'h0, 1);        chk_out("stall e1",  1, 8'h01, 0, 1);
        drive(1, 0, 32'h0, 0);        chk_out("stall e2a", 1, 8'h02, 0, 1);
        drive(1, 0, 32'h0, 0);        chk_out("stall e2b", 1, 8'h02, 0, 1);
        drive(1, 0, 32'h0, 1);        chk_out("stall e2c", 1, 8'h02, 0, 1);
        drive(1, 0, 32'h0, 1);        chk_out("stall e3",  1, 8'h03, 0, 1);
        drive(1, 0, 32'h0, 1);        chk_out("stall e4",  1, 8'h04, 1, 1);
        drive(1, 0, 32'h0, 1);        chk_out("stall end", 0, 8'h00, 0, 1);

        // Reset mid-stream with a vector waiting in the shadow drops both.
        drive(1, 1, 32'h04030201, 1); chk_out("rst acc A", 0, 8'h00, 0, 1);
        drive(1, 1, 32'h08070605, 1); chk_out("rst acc B", 1, 8'h01, 0, 1);
        drive(0, 0, 32'h0, 1);        chk_out("rst pulse", 1, 8'h02, 0, 0);
        drive(1, 0, 32'h0, 1);        chk_out("rst after", 0, 8'h00, 0, 1);
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 32'h0, 1);
            chk_out($sformatf("rst quiet%0d", i), 0, 8'h00, 0, 1);
        end

        // Randomized traffic against the reference model; first cycle resets both sides.
        m_cur.delete();
        m_shadow_full = 0;
        m_dq.delete();
        for (int k = 0; k < SKEW; k++) m_dq.push_back('0);

        for (int i = 0; i < 3000; i++) begin
            r  = (i == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
            iv = $urandom_range(0, 1);
            en = ($urandom_range(0, 3) != 0);
            d  = $urandom;
            drive(r, iv, d, en);

            m_valid = (m_cur.size() > 0);
            m_data  = m_valid ? m_cur[0] : 8'h00;
            m_last  = (m_cur.size() == 1);
            m_ready = r & !m_shadow_full;
            sk      = (SKEW > 0) ? m_dq[0] : {m_valid, m_last, m_data};

            if (i > 0) begin
                chk_out($sformatf("rnd%0d", i), m_valid, m_data, m_last, m_ready);
                chk($sformatf("rnd%0d skew valid", i), s_valid, sk[9]);
                chk($sformatf("rnd%0d skew last", i),  s_last,  sk[8]);
                chk($sformatf("rnd%0d skew data", i),  s_data,  sk[7:0]);
                chk($sformatf("rnd%0d skew ready", i), s_ready, m_ready);
            end

            @(posedge clk);
            if (!r) begin
                m_cur.delete();
                m_shadow_full = 0;
                for (int k = 0; k < SKEW; k++) m_dq[k] = '0;
            end else begin
                acc = iv & m_ready;
                if (en && SKEW > 0) begin
                    m_dq.push_back({m_valid, m_last, m_data});
                    void'(m_dq.pop_front());
                end
                if (m_cur.size() == 0) begin
                    if (acc) m_load(d);
                end else if (en && m_cur.size() == 1) begin
                    if (m_shadow_full) begin
                        m_load(m_shadow);
                        m_shadow_full = 0;
                    end else if (acc) begin
                        m_load(d);
                    end else begin
                        m_cur.delete();
                    end
                end else begin
                    if (en) void'(m_cur.pop_front());
                    if (acc) begin
                        m_shadow      = d;
                        m_shadow_full = 1;
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
